// File: rtl/ffd_delay_line_pkg.sv
// ffd_delay_line_pkg
//   Shared constants for the tapped delay line and its consumers:
//   default sample width and the fill-state encoding exported to MAC stages.
package ffd_delay_line_pkg;

  localparam int N = 18;  // default fixed-point sample width

  typedef enum logic [1:0] {
    FS_EMPTY   = 2'b00,
    FS_FILLING = 2'b01,
    FS_FULL    = 2'b10
  } fill_state_t;

endpackage

// File: rtl/ffd_delay_line_stage.sv
// ffd_stage
//   One WIDTH-bit register with enable, clear and synchronous active-low reset.
//   Exports both the registered value (q) and the value it will take at the
//   next rising edge (q_next), so the top can present look-ahead taps.
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-low reset
//   en      in   load d at the next edge
//   clr     in   synchronous clear (wins over en)
//   d       in   WIDTH  data in
//   q       out  WIDTH  registered data
//   q_next  out  WIDTH  next-state data
module ffd_stage #(
  parameter int WIDTH = ffd_delay_line_pkg::N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    if (!reset || clr) q_next = '0;
    else if (en)       q_next = d;
  end

  always_ff @(posedge clk) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ffd_delay_line.sv
// ffd_delay_line
//   Tapped delay line of DEPTH enable-gated registers. Every tap is visible in
//   parallel (tap0 newest); a saturating fill counter and a small FSM report
//   when all taps hold valid samples.
// Parameters
//   WIDTH  sample width
//   DEPTH  number of taps, >= 2
//   CNT_W  fill counter width, 2**CNT_W > DEPTH
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   enable    in   accept din and advance the line
//   flush     in   synchronous clear of line and fill count (wins over enable)
//   din       in   WIDTH        new sample
//   taps      out  WIDTH*DEPTH  tap k at [WIDTH*(k+1)-1 : WIDTH*k]
//   dout      out  WIDTH        oldest tap (tap DEPTH-1)
//   fill_cnt  out  CNT_W        valid samples held, 0..DEPTH
//   empty     out  fill_cnt == 0
//   full      out  fill_cnt == DEPTH
// Configuration
//   TAP_LOOKAHEAD_EN  when defined, all outputs show next-state values
//                     combinationally; otherwise they come straight from registers.
module ffd_delay_line
  import ffd_delay_line_pkg::*;
#(
  parameter int WIDTH = N,
  parameter int DEPTH = 9,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [WIDTH-1:0]       dout,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   empty,
  output logic                   full
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_nq, stage_d;
  logic [CNT_W-1:0]            cnt_q, cnt_nxt;
  fill_state_t                 state_q, state_nxt, state_out;

  // Stage 0 takes din, every later stage takes its predecessor.
  assign stage_d[0] = din;
  for (genvar k = 1; k < DEPTH; k++) begin : g_chain
    assign stage_d[k] = stage_q[k-1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ffd_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (enable),
      .clr    (flush),
      .d      (stage_d[k]),
      .q      (stage_q[k]),
      .q_next (stage_nq[k])
    );
  end

  // Fill counter saturates at DEPTH; only reset/flush bring it down.
  always_comb begin
    cnt_nxt = cnt_q;
    if (!reset || flush)              cnt_nxt = '0;
    else if (enable && cnt_q != CNT_MAX) cnt_nxt = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FS_EMPTY;
    else        state_q <= state_nxt;
  end

  // FSM: next state (reset folded in so look-ahead outputs read zero during reset)
  always_comb begin
    state_nxt = state_q;
    if (!reset || flush) state_nxt = FS_EMPTY;
    else if (enable) begin
      case (state_q)
        FS_EMPTY:   state_nxt = FS_FILLING;
        FS_FILLING: if (cnt_q == CNT_LAST) state_nxt = FS_FULL;
        FS_FULL:    state_nxt = FS_FULL;
        default:    state_nxt = FS_EMPTY;
      endcase
    end
  end

  // FSM: outputs
`ifdef TAP_LOOKAHEAD_EN
  assign state_out = state_nxt;
  assign taps      = stage_nq;
  assign fill_cnt  = cnt_nxt;
`else
  assign state_out = state_q;
  assign taps      = stage_q;
  assign fill_cnt  = cnt_q;
`endif

  always_comb begin
    empty = (state_out == FS_EMPTY);
    full  = (state_out == FS_FULL);
  end

  assign dout = taps[WIDTH*(DEPTH-1) +: WIDTH];

endmodule

// File: tb/tb_ffd_delay_line.sv
module tb_ffd_delay_line;
  localparam int WIDTH = 18;
  localparam int DEPTH = 9;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   reset, enable, flush;
  logic [WIDTH-1:0]       din;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [WIDTH-1:0]       dout;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   empty, full;

  int checks = 0;
  int errors = 0;

  ffd_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .din(din),
    .taps(taps), .dout(dout), .fill_cnt(fill_cnt), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst; logic en; logic fl; int d;
    int fill; logic emp; logic ful; int tap0; int dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic f, input int d,
                     input int fc, input logic em, input logic fu, input int t0, input int dq);
    vec_t v;
    v.rst = r; v.en = e; v.fl = f; v.d = d;
    v.fill = fc; v.emp = em; v.ful = fu; v.tap0 = t0; v.dout = dq;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic f, input int d);
    reset = r; enable = e; flush = f; din = WIDTH'(d);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset asserted with junk input
    add(0,1,0,'h3FFFF, 0,1,0, 0,0);
    add(0,1,0,'h3FFFF, 0,1,0, 0,0);
    // fill with 1..9
    for (int i = 1; i <= 9; i++)
      add(1,1,0,i, i,0,(i==9), i,(i==9) ? 1 : 0);
    // 10th sample: oldest drops, count saturates
    add(1,1,0,10, 9,0,1, 10,2);
    // enable toggling
    add(1,0,0,11, 9,0,1, 10,2);
    add(1,1,0,12, 9,0,1, 12,3);
    add(1,0,0,13, 9,0,1, 12,3);
    add(1,1,0,14, 9,0,1, 14,4);
    // flush beats enable, din=5 dropped
    add(1,1,1,5,  0,1,0, 0,0);
    add(1,0,0,7,  0,1,0, 0,0);
    // four samples then reset mid-fill
    for (int i = 1; i <= 4; i++)
      add(1,1,0,20+i, i,0,0, 20+i,0);
    add(0,1,0,99, 0,1,0, 0,0);
    add(1,1,0,31, 1,0,0, 31,0);
    add(1,0,0,32, 1,0,0, 31,0);

    drive(0,0,0,0);
    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].d);
      tick();
      chk($sformatf("v%0d fill", i), int'(fill_cnt), vecs[i].fill);
      chk($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("v%0d full", i), int'(full), int'(vecs[i].ful));
      chk($sformatf("v%0d tap0", i), int'(taps[WIDTH-1:0]), vecs[i].tap0);
      chk($sformatf("v%0d dout", i), int'(dout), vecs[i].dout);
    end

    // full line: every tap position
    drive(1,0,1,0); tick();
    for (int i = 1; i <= 9; i++) begin drive(1,1,0,i); tick(); end
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("tap%0d", k), int'(taps[WIDTH*k +: WIDTH]), 9 - k);

    // held cycles with changing din leave all taps alone
    for (int i = 0; i < 3; i++) begin drive(1,0,0,100+i); tick(); end
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("hold tap%0d", k), int'(taps[WIDTH*k +: WIDTH]), 9 - k);

    // timing of tap0 relative to enable
    drive(1,0,1,0); tick();
    drive(1,1,0,'h20000); #1;
`ifdef TAP_LOOKAHEAD_EN
    chk("same-cycle tap0", int'(taps[WIDTH-1:0]), 'h20000);
    chk("same-cycle fill", int'(fill_cnt), 1);
`else
    chk("same-cycle tap0", int'(taps[WIDTH-1:0]), 0);
    chk("same-cycle fill", int'(fill_cnt), 0);
`endif
    tick();
    drive(1,0,0,0);
    #1;
    chk("after-edge tap0", int'(taps[WIDTH-1:0]), 'h20000);
    chk("after-edge empty", int'(empty), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
